// File: rtl/paillier_host_pkg.sv
// Shared definitions for the Paillier host loader.
// Holds the op one-hot codes, the operand slot indices, the header field
// positions, the loader FSM state type and a couple of small helpers.
package paillier_host_pkg;

  localparam logic [3:0] OP_ENC = 4'b0001;
  localparam logic [3:0] OP_DEC = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int SLOT_M      = 0;
  localparam int SLOT_R      = 1;
  localparam int SLOT_C      = 2;
  localparam int SLOT_C1     = 3;
  localparam int SLOT_C2     = 4;
  localparam int SLOT_N      = 5;
  localparam int SLOT_EXP_N  = 6;
  localparam int SLOT_G      = 7;
  localparam int SLOT_LAMBDA = 8;
  localparam int SLOT_MU     = 9;
  localparam int NUM_SLOTS   = 10;

  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int MASK_LSB = 4;
  localparam int MASK_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_START,
    S_WAIT_DONE,
    S_UNLOAD,
    S_DRAIN
  } fsm_t;

  // Index of the lowest set bit; slots are loaded in ascending order.
  function automatic logic [3:0] lowest_slot(input logic [MASK_W-1:0] m);
    lowest_slot = 4'd0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (m[i]) lowest_slot = 4'(i);
  endfunction

  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    return (op == OP_ENC) || (op == OP_DEC) || (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/paillier_result_serializer.sv
// Parallel-load, word-serial output stage for the core result.
// Ports: clk/rst; load + load_data capture RSA_WIDTH bits in one cycle;
// out_valid/out_ready/out_data/out_last emit DATA_NUMBER words LS-first,
// out_last on the final word.
module paillier_result_serializer #(
  parameter int RSA_WIDTH   = 4096,
  parameter int DATA_WIDTH  = 128,
  parameter int DATA_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [RSA_WIDTH-1:0]  load_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CNT_W = $clog2(DATA_NUMBER);

  logic [RSA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]     cnt;

  // Shifting right keeps the current word in the low slice, so out_data is
  // naturally held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      cnt       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (cnt == CNT_W'(DATA_NUMBER - 1)) begin
        out_valid <= 1'b0;
      end else begin
        shreg <= shreg >> DATA_WIDTH;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign out_data = shreg[DATA_WIDTH-1:0];
  assign out_last = out_valid && (cnt == CNT_W'(DATA_NUMBER - 1));

endmodule

// File: rtl/paillier_host_loader.sv
// Stream-side command front end / initiator for the Paillier core.
// Ports: clk, rst (sync, active-high); in_* command/operand stream
// (header word then masked operands, LS word first); out_* result stream;
// go/state/op_* drive the core; result/done come back from it; err is a
// sticky protocol-error flag cleared only by rst.
module paillier_host_loader
  import paillier_host_pkg::*;
#(
  parameter int RSA_WIDTH   = 4096,
  parameter int DATA_WIDTH  = 128,
  parameter int DATA_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  go,
  output logic [3:0]            state,
  output logic [RSA_WIDTH-1:0]  op_m,
  output logic [RSA_WIDTH-1:0]  op_r,
  output logic [RSA_WIDTH-1:0]  op_c,
  output logic [RSA_WIDTH-1:0]  op_c1,
  output logic [RSA_WIDTH-1:0]  op_c2,
  output logic [RSA_WIDTH-1:0]  op_n,
  output logic [RSA_WIDTH-1:0]  op_exp_n,
  output logic [RSA_WIDTH-1:0]  op_g,
  output logic [RSA_WIDTH-1:0]  op_lambda,
  output logic [RSA_WIDTH-1:0]  op_mu,
  input  logic [RSA_WIDTH-1:0]  result,
  input  logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(DATA_NUMBER);

  fsm_t                 cur, nxt;
  logic [RSA_WIDTH-1:0] ops [NUM_SLOTS];
  logic [MASK_W-1:0]    mask_rem;
  logic [CNT_W-1:0]     word_cnt;
  logic [OP_W-1:0]      op_q;
  logic                 set_err;
  logic                 ser_load;

  logic              in_fire;
  logic [OP_W-1:0]   hdr_op;
  logic [MASK_W-1:0] hdr_mask;
  logic [3:0]        cur_slot;
  logic              last_word;
  logic              final_word;

  assign in_fire    = in_valid && in_ready;
  assign hdr_op     = in_data[OP_LSB +: OP_W];
  assign hdr_mask   = in_data[MASK_LSB +: MASK_W];
  assign cur_slot   = lowest_slot(mask_rem);
  assign last_word  = (word_cnt == CNT_W'(DATA_NUMBER - 1));
  // Final word of the command: last word of the only slot still pending.
  assign final_word = last_word && ((mask_rem & (mask_rem - MASK_W'(1))) == '0);

  always_comb begin
    nxt      = cur;
    set_err  = 1'b0;
    in_ready = 1'b0;
    go       = 1'b0;
    ser_load = 1'b0;
    case (cur)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_fire) begin
          if (!op_is_valid(hdr_op)) begin
            set_err = 1'b1;
            nxt     = S_DISCARD;
          end else if (hdr_mask == '0) begin
            if (in_last) begin
              nxt = S_START;
            end else begin
              set_err = 1'b1;
              nxt     = S_DISCARD;
            end
          end else if (in_last) begin
            // Operands announced but the command already ended.
            set_err = 1'b1;
            nxt     = S_IDLE;
          end else begin
            nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_fire) begin
          if (final_word) begin
            if (in_last) begin
              nxt = S_START;
            end else begin
              set_err = 1'b1;
              nxt     = S_DISCARD;
            end
          end else if (in_last) begin
            set_err = 1'b1;
            nxt     = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        in_ready = 1'b1;
        if (in_fire && in_last) nxt = S_IDLE;
      end
      S_START: begin
        go  = 1'b1;
        nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        go = 1'b1;
        if (done) begin
          ser_load = 1'b1;
          nxt      = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (out_valid && out_ready && out_last) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!done) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IDLE;
      err      <= 1'b0;
      state    <= '0;
      op_q     <= '0;
      mask_rem <= '0;
      word_cnt <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) ops[s] <= '0;
    end else begin
      cur <= nxt;
      if (set_err) err <= 1'b1;

      if (cur == S_IDLE && in_fire) begin
        op_q     <= hdr_op;
        mask_rem <= hdr_mask;
        word_cnt <= '0;
      end

      if (cur == S_LOAD && in_fire) begin
        for (int s = 0; s < NUM_SLOTS; s++)
          if (cur_slot == 4'(s)) ops[s][word_cnt*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        if (last_word) begin
          word_cnt <= '0;
          mask_rem <= mask_rem & (mask_rem - MASK_W'(1));
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      // A header-only command enters START before op_q is written.
      if (nxt == S_START && cur != S_START)
        state <= (cur == S_IDLE) ? hdr_op : op_q;
      else if (nxt == S_IDLE && cur != S_IDLE)
        state <= '0;
    end
  end

  assign op_m      = ops[SLOT_M];
  assign op_r      = ops[SLOT_R];
  assign op_c      = ops[SLOT_C];
  assign op_c1     = ops[SLOT_C1];
  assign op_c2     = ops[SLOT_C2];
  assign op_n      = ops[SLOT_N];
  assign op_exp_n  = ops[SLOT_EXP_N];
  assign op_g      = ops[SLOT_G];
  assign op_lambda = ops[SLOT_LAMBDA];
  assign op_mu     = ops[SLOT_MU];

  paillier_result_serializer #(
    .RSA_WIDTH  (RSA_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_NUMBER(DATA_NUMBER)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .load_data(result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

endmodule

// File: doc/paillier_host_loader.md
# paillier_host_loader

Stream-side command front end for `paillier_demo_overall_top`; acts as the hardware initiator toward the core.
- Accepts a DATA_WIDTH-wide valid/ready input stream carrying a command header plus 4096-bit operands split into words.
- Assembles operands, drives `go`/`state`/operands into the core, and waits for `done`.
- Returns the RSA_WIDTH `result` as a DATA_WIDTH-wide output stream.

## Interface
Parameters:
- RSA_WIDTH, 4096, operand/result width
- DATA_WIDTH, 128, stream word width
- DATA_NUMBER, 32, words per operand (RSA_WIDTH/DATA_WIDTH)

Ports:
- clk  in  1  sole clock, all logic rising-edge
- rst  in  1  reset; synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  input-stream handshake
- in_data  in  DATA_WIDTH  header or operand word
- in_last  in  1  marks the final word of a command
- out_valid / out_ready  out / in  1 / 1  result-stream handshake
- out_data  out  DATA_WIDTH  result word
- out_last  out  1  high on result word DATA_NUMBER-1
- go  out  1  core start
- state  out  4  one-hot op: 0001 encrypt, 0010 decrypt, 0100 homo add, 1000 homo mul
- op_m, op_r, op_c, op_c1, op_c2, op_n, op_exp_n, op_g, op_lambda, op_mu  out  RSA_WIDTH each  core operands
- result  in  RSA_WIDTH  core result
- done  in  1  core completion
- err  out  1  sticky protocol error, cleared only by rst

## Operation
Header word fields:
- [3:0]: op
- [13:4]: load mask, one bit per slot, in the order m, r, c, c1, c2, n, exp_n, g, lambda, mu (bit 4 = m … bit 13 = mu)
- remaining bits are ignored

Loading:
- For each set mask bit, in ascending order, DATA_NUMBER words follow, least-significant word first. Word k lands in bits [k*DATA_WIDTH +: DATA_WIDTH].
- Slots not in the mask keep their previous values, so `n`/`exp_n` can be reused across commands.
- The number of expected words is 32 × popcount(mask). in_last must arrive on the last expected word; when the mask is 0, in_last arrives on the header itself.

FSM:
- IDLE: accept the header. An invalid op (not one-hot) sets err and moves to DISCARD; this also applies when in_last is on the header. A valid op with mask 0 and in_last goes to START. Mask 0 without in_last sets err and moves to DISCARD. Otherwise go to LOAD.
- LOAD: a slot index and a word counter (0..DATA_NUMBER-1) advance on each accepted word. in_last before the expected final word sets err, returns to IDLE, and does not launch. A final word without in_last sets err and moves to DISCARD. A final word with in_last goes to START.
- DISCARD: swallow words until in_last is accepted, then go to IDLE.
- START: drive `state`, assert go, move to WAIT_DONE.
- WAIT_DONE: hold go high. When done is high, capture result into the output shift register, drop go on the next cycle, and move to UNLOAD.
- UNLOAD: present words LS-first. After the handshake on word 31, go to DRAIN.
- DRAIN: wait for done low, then go to IDLE.

## Timing
Reset behaviour:
- rst clears the FSM to IDLE, and clears go, state, all op_* registers, out_valid, out_last, out_data, and err to 0.
- rst mid-operation aborts immediately, including during WAIT_DONE.

Input side:
- in_ready is combinational: 1 in IDLE, LOAD and DISCARD; 0 otherwise. It is therefore high in the first cycle after rst falls.
- One word is accepted per cycle when in_valid && in_ready.

Launch and result:
- go rises in the cycle after the final operand word (or the header) is accepted.
- result is sampled in the first cycle done=1. out_valid rises the next cycle.
- out_data and out_last are held stable while out_valid && !out_ready.
- The full result streams in 32 cycles at out_ready=1.

State output: `state` is held from START until IDLE is re-entered.

## Structure
- Package `paillier_host_pkg` holds:
  - op one-hot constants
  - slot index constants SLOT_M…SLOT_MU (0..9)
  - header field positions (OP_LSB=0, MASK_LSB=4, MASK_W=10)
  - FSM state enum
- Sub-module `paillier_result_serializer`: loads RSA_WIDTH in parallel, then emits DATA_NUMBER words on valid/ready with out_last.

## Test plan
Benches use a stub core that raises done for 1 cycle, 5 cycles after go.
- Decrypt load: header 0x3642, then 160 words carrying c=33524, n=209, exp_n=43681, lambda=90, mu=72 with in_last on word 160 → op_* registers hold those values, state=0010, go rises 1 cycle after the last accept, err=0.
- Operand reuse: after the decrypt command, header 0x0184 plus 64 words c1=226, c2=3409 → op_n is still 209, op_exp_n is still 43681, state=0100.
- Result stream: stub returns result=0x…0123_4567 in word 0 and 0xA5 in word 31 → 32 words LS-first, out_last only on the 32nd word. With out_ready toggling 1/0, each word is seen exactly once and stays stable while stalled.
- Bad op: header 0x0003 with in_last → err=1, no go, in_ready high again the next cycle.
- Early last: header 0x0208, in_last on operand word 10 → err=1, no go, FSM back in IDLE. A following valid command still launches.
- Reset in WAIT_DONE: assert rst 2 cycles after go → next cycle go=0, out_valid=0, all op_*=0, err=0.
